bit_timer_seq: RTL
==================

// Module: bit_timer_seq
// PURPOSE
// Parametrised successor to the RX bit-time counter. Generates the end-of-bit pulse (BTU)
// plus a mid-bit sample pulse (MID) and tracks bit index across a whole frame.
// An optional half-length first bit centres sampling on the start bit.
// Sits between the RX/TX control FSMs and the shift registers; one instance per engine.
// PARAMETERS
// CNT_W   18  width of baud_count and the internal cycle counter
// BIT_W   4   width of num_bits / bit_idx (frame up to 2**BIT_W-1 bits)
// PORTS
// Clk         in   1      system clock, rising edge
// Rst         in   1      asynchronous reset, active low
// start       in   1      level: 1 = run frame timing, 0 = abort/idle
// half_first  in   1      1 = first bit period is half length (RX start-bit centring)
// baud_count  in   CNT_W  clocks per bit; sampled only on IDLE->RUN
// num_bits    in   BIT_W  bits per frame incl. start/stop; sampled on IDLE->RUN
// BTU         out  1      1-cycle pulse on last clock of each bit period
// MID         out  1      1-cycle pulse at mid-point of each full-length bit
// done        out  1      1-cycle pulse, coincident with BTU of final bit
// busy        out  1      1 while state == RUN
// bit_idx     out  BIT_W  index of bit currently being timed (0-based)
// BEHAVIOUR
// - Reset (Rst=0, async): state=IDLE, count=0, bit_idx=0, baud_lat=1, nb_lat=1;
//   BTU=MID=done=busy=0.
// - States: IDLE, RUN, HOLD.
//   IDLE: start=1 at edge -> RUN; latch baud_lat=(baud_count==0)?1:baud_count,
//     nb_lat=(num_bits==0)?1:num_bits, hf_lat=half_first; count=0, bit_idx=0.
//   RUN: start=0 at edge -> IDLE (abort; count, bit_idx cleared, no done).
//     BTU & bit_idx==nb_lat-1 -> HOLD. Else BTU -> count=0, bit_idx+1.
//     Else count+1.
//   HOLD: counters frozen at 0; stay until start=0, then IDLE. Prevents re-trigger
//     without start being dropped for at least one cycle.
// - limit = (bit_idx==0 & hf_lat) ? max(baud_lat>>1,1) : baud_lat (CNT_W-bit, no overflow).
// - BTU  = RUN & (count == limit-1). Bit period = exactly limit clocks;
//   first BTU is limit cycles after the edge that enters RUN.
// - MID  = RUN & !(bit_idx==0 & hf_lat) & (count == baud_lat>>1). With baud_lat=1,
//   MID and BTU coincide at count 0.
// - done = BTU & (bit_idx == nb_lat-1). busy = (state==RUN).
// - BTU/MID/done are combinational decodes of registered state only (no input paths);
//   they are glitch-free at clock edges and never asserted outside RUN.
// - baud_count/num_bits/half_first changes while RUN/HOLD are ignored until next IDLE->RUN.
// - count never exceeds limit-1; bit_idx never exceeds nb_lat-1 (no wrap).
// - start=0 on same edge as final BTU: abort wins, next state IDLE (done still pulsed
//   in that cycle since it is decoded from current state).
// - Rst asserted mid-frame: immediate return to reset values regardless of state.
// TESTING
// T1 baud=4, num_bits=3, hf=0, start held 1: BTU at RUN cycles 3,7,11; MID at 2,6,10;
//    done with 3rd BTU; busy drops next cycle; HOLD until start=0.
// T2 baud=16, num_bits=10, hf=1: first BTU after 8 clocks, no MID in bit 0; then BTU
//    every 16, MID at count 8; done after 8+9*16=152 clocks; bit_idx 0..9.
// T3 baud=0 and baud=1, num_bits=0: treated as 1/1; BTU, MID, done all pulse on first
//    RUN cycle; busy 1 cycle.
// T4 change baud_count 8->3 mid-frame: periods stay 8 until frame end; next frame uses 3.
// T5 drop start at count=5 of bit 2 (baud=8): next cycle IDLE, bit_idx=0, no done;
//    re-raise start -> fresh frame from bit 0.
// T6 assert Rst low mid-RUN (async, between edges): outputs zero immediately; after
//    release with start=1, one IDLE cycle then RUN with freshly latched values.

Source files
------------

// File: rtl/bit_timer_seq.sv
// Bit-period timer for the UART engines: end-of-bit (BTU), mid-bit (MID) and
// end-of-frame (done) strobes, with an optional half-length first bit.
module bit_timer_seq #(
    parameter int CNT_W = 18,
    parameter int BIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             half_first_i,
    input  logic [CNT_W-1:0] baud_count_i,
    input  logic [BIT_W-1:0] num_bits_i,
    output logic             btu_o,
    output logic             mid_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [BIT_W-1:0] bit_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [BIT_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] baud_lat_q;
    logic [BIT_W-1:0] nb_lat_q;
    logic             hf_lat_q;

    logic             run;
    logic             first_half;
    logic [CNT_W-1:0] half_baud;
    logic [CNT_W-1:0] limit;
    logic             last_bit;
    logic             btu;

    // All strobes decode registered state only, so no input reaches an output.
    always_comb begin
        run        = (state_q == S_RUN);
        first_half = hf_lat_q && (bit_idx_q == '0);
        half_baud  = baud_lat_q >> 1;
        limit      = baud_lat_q;
        if (first_half) begin
            limit = (half_baud == '0) ? CNT_W'(1) : half_baud;
        end
        last_bit   = (bit_idx_q == nb_lat_q - BIT_W'(1));
        btu        = run && (count_q == limit - CNT_W'(1));
    end

    assign btu_o     = btu;
    assign mid_o     = run && !first_half && (count_q == half_baud);
    assign done_o    = btu && last_bit;
    assign busy_o    = run;
    assign bit_idx_o = bit_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            bit_idx_q  <= '0;
            baud_lat_q <= CNT_W'(1);
            nb_lat_q   <= BIT_W'(1);
            hf_lat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    count_q   <= '0;
                    bit_idx_q <= '0;
                    if (start_i) begin
                        state_q    <= S_RUN;
                        baud_lat_q <= (baud_count_i == '0) ? CNT_W'(1) : baud_count_i;
                        nb_lat_q   <= (num_bits_i == '0) ? BIT_W'(1) : num_bits_i;
                        hf_lat_q   <= half_first_i;
                    end
                end
                S_RUN: begin
                    // Abort takes priority over a coincident final BTU.
                    if (!start_i) begin
                        state_q   <= S_IDLE;
                        count_q   <= '0;
                        bit_idx_q <= '0;
                    end else if (btu && last_bit) begin
                        state_q   <= S_HOLD;
                        count_q   <= '0;
                        bit_idx_q <= '0;
                    end else if (btu) begin
                        count_q   <= '0;
                        bit_idx_q <= bit_idx_q + BIT_W'(1);
                    end else begin
                        count_q   <= count_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    count_q   <= '0;
                    bit_idx_q <= '0;
                    if (!start_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    count_q   <= '0;
                    bit_idx_q <= '0;
                end
            endcase
        end
    end

endmodule
